// File: rtl/fdivsqrt_intpostproc.sv
// Integer post-processor for the divide/sqrt unit: resolves the residual sign, corrects
// quotient or remainder, normalizes, sign-corrects and hands the XLEN result to writeback.
module fdivsqrt_intpostproc #(
   parameter int XLEN    = 64,
   parameter int DIVb    = 66,
   parameter int DIVBLEN = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               StartM,
   input  logic               FlushM,
   input  logic [DIVb+3:0]    WS,
   input  logic [DIVb+3:0]    WC,
   input  logic [DIVb+3:0]    D,
   input  logic [DIVb:0]      U,
   input  logic [DIVb:0]      UM,
   input  logic [DIVBLEN-1:0] IntNormShiftM,
   input  logic               RemOpM,
   input  logic               ALTBM,
   input  logic               BZeroM,
   input  logic               AsM,
   input  logic               BsM,
   input  logic               W64M,
   input  logic [XLEN-1:0]    AM,
   output logic               BusyM,
   output logic               ResultValidM,
   input  logic               ResultReadyW,
   output logic [XLEN-1:0]    IntDivResultM
);

   typedef enum logic [2:0] {IDLE, SUM, SHIFT, SIGN, HOLD} state_t;

   state_t                    state_q, state_d;
   logic signed [DIVb+3:0]    ws_q, ws_d, wc_q, wc_d, d_q, d_d;
   logic [DIVb:0]             u_q, u_d, um_q, um_d;
   logic [DIVBLEN-1:0]        shamt_q, shamt_d;
   logic                      remop_q, remop_d, as_q, as_d, bs_q, bs_d, w64_q, w64_d;
   logic [DIVb+3:0]           pre_q, pre_d;
   logic [XLEN-1:0]           sh_q, sh_d;
   logic [XLEN-1:0]           result_q, result_d;
   logic signed [DIVb+3:0]    w_sum;
   logic                      neg_sticky;
   logic [XLEN-1:0]           special;

   function automatic logic [XLEN-1:0] norm_shift(input logic [DIVb+3:0] pre,
                                                  input logic [DIVBLEN-1:0] amt);
      norm_shift = XLEN'(pre >> amt);
   endfunction

   function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] r, input logic neg);
      logic signed [XLEN-1:0] s;
      s = $signed(r);
      sign_fix = neg ? -s : s;
   endfunction

   // A 32-bit op keeps its result in the low word; bit 31 fills the upper word.
   function automatic logic [XLEN-1:0] w64_ext(input logic [XLEN-1:0] r, input logic w64);
      w64_ext = r;
      if (w64 && XLEN > 32)
         for (int i = 32; i < XLEN; i++) w64_ext[i] = r[31];
   endfunction

   always_comb begin
      state_d    = state_q;
      ws_d       = ws_q;
      wc_d       = wc_q;
      d_d        = d_q;
      u_d        = u_q;
      um_d       = um_q;
      shamt_d    = shamt_q;
      remop_d    = remop_q;
      as_d       = as_q;
      bs_d       = bs_q;
      w64_d      = w64_q;
      pre_d      = pre_q;
      sh_d       = sh_q;
      result_d   = result_q;
      w_sum      = ws_q + wc_q;
      neg_sticky = w_sum[DIVb+3];
      special    = AM;
      if (!RemOpM) special = BZeroM ? '1 : '0;

      if (FlushM) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (StartM) begin
               if (BZeroM || ALTBM) begin
                  result_d = w64_ext(special, W64M);
                  state_d  = HOLD;
               end else begin
                  ws_d    = WS;
                  wc_d    = WC;
                  d_d     = D;
                  u_d     = U;
                  um_d    = UM;
                  shamt_d = IntNormShiftM;
                  remop_d = RemOpM;
                  as_d    = AsM;
                  bs_d    = BsM;
                  w64_d   = W64M;
                  state_d = SUM;
               end
            end
            // SUM -> SHIFT: a negative residual means the last digit overshot by one.
            SUM: begin
               if (remop_q) pre_d = neg_sticky ? w_sum + d_q : w_sum;
               else         pre_d = {3'b000, neg_sticky ? um_q : u_q};
               state_d = SHIFT;
            end
            // SHIFT -> SIGN
            SHIFT: begin
               sh_d    = norm_shift(pre_q, shamt_q);
               state_d = SIGN;
            end
            // SIGN -> HOLD
            SIGN: begin
               result_d = w64_ext(sign_fix(sh_q, remop_q ? as_q : (as_q ^ bs_q)), w64_q);
               state_d  = HOLD;
            end
            HOLD:    if (ResultReadyW) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         ws_q     <= '0;
         wc_q     <= '0;
         d_q      <= '0;
         u_q      <= '0;
         um_q     <= '0;
         shamt_q  <= '0;
         remop_q  <= 1'b0;
         as_q     <= 1'b0;
         bs_q     <= 1'b0;
         w64_q    <= 1'b0;
         pre_q    <= '0;
         sh_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         ws_q     <= ws_d;
         wc_q     <= wc_d;
         d_q      <= d_d;
         u_q      <= u_d;
         um_q     <= um_d;
         shamt_q  <= shamt_d;
         remop_q  <= remop_d;
         as_q     <= as_d;
         bs_q     <= bs_d;
         w64_q    <= w64_d;
         pre_q    <= pre_d;
         sh_q     <= sh_d;
         result_q <= result_d;
      end
   end

   assign BusyM         = (state_q != IDLE);
   assign ResultValidM  = (state_q == HOLD);
   assign IntDivResultM = result_q;

endmodule

// File: tb/tb_fdivsqrt_intpostproc.sv
// Bench for fdivsqrt_intpostproc: vector table with a result scoreboard plus
// hand-written handshake, ignored-start, flush and mid-operation reset sequences.
module tb_fdivsqrt_intpostproc;
   localparam int XLEN = 64, DIVb = 66, DIVBLEN = 7;

   typedef struct packed {
      logic [DIVb+3:0]    ws, wc, d;
      logic [DIVb:0]      u, um;
      logic [DIVBLEN-1:0] sh;
      logic               rem, altb, bz, as_, bs_, w64;
      logic [XLEN-1:0]    am, exp;
      logic [3:0]         lat;
   } vec_t;

   logic clk = 1'b0, reset = 1'b1;
   logic StartM = 0, FlushM = 0, RemOpM = 0, ALTBM = 0, BZeroM = 0, AsM = 0, BsM = 0, W64M = 0;
   logic [DIVb+3:0] WS = '0, WC = '0, D = '0;
   logic [DIVb:0] U = '0, UM = '0;
   logic [DIVBLEN-1:0] IntNormShiftM = '0;
   logic [XLEN-1:0] AM = '0;
   logic ResultReadyW = 0;
   logic BusyM, ResultValidM;
   logic [XLEN-1:0] IntDivResultM;

   int nvec = 0, nerr = 0;
   logic [XLEN-1:0] sb[$];
   vec_t tbl[14];

   always #5 clk = ~clk;

   fdivsqrt_intpostproc #(.XLEN(XLEN), .DIVb(DIVb), .DIVBLEN(DIVBLEN)) dut (
      .clk(clk), .reset(reset), .StartM(StartM), .FlushM(FlushM), .WS(WS), .WC(WC), .D(D),
      .U(U), .UM(UM), .IntNormShiftM(IntNormShiftM), .RemOpM(RemOpM), .ALTBM(ALTBM),
      .BZeroM(BZeroM), .AsM(AsM), .BsM(BsM), .W64M(W64M), .AM(AM), .BusyM(BusyM),
      .ResultValidM(ResultValidM), .ResultReadyW(ResultReadyW), .IntDivResultM(IntDivResultM));

   function automatic vec_t mk(logic [DIVb+3:0] ws, logic [DIVb+3:0] wc, logic [DIVb+3:0] d,
                               logic [DIVb:0] u, logic [DIVb:0] um, logic [DIVBLEN-1:0] sh,
                               logic rem, logic altb, logic bz, logic as_, logic bs_, logic w64,
                               logic [XLEN-1:0] am, logic [XLEN-1:0] exp, logic [3:0] lat);
      vec_t v;
      v.ws = ws; v.wc = wc; v.d = d; v.u = u; v.um = um; v.sh = sh; v.rem = rem;
      v.altb = altb; v.bz = bz; v.as_ = as_; v.bs_ = bs_; v.w64 = w64; v.am = am;
      v.exp = exp; v.lat = lat;
      return v;
   endfunction

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      WS = v.ws; WC = v.wc; D = v.d; U = v.u; UM = v.um; IntNormShiftM = v.sh;
      RemOpM = v.rem; ALTBM = v.altb; BZeroM = v.bz; AsM = v.as_; BsM = v.bs_;
      W64M = v.w64; AM = v.am;
   endtask

   task automatic wait_valid(input string name, output int cyc);
      cyc = 0;
      while (ResultValidM !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (ResultValidM !== 1'b1) begin
         nvec++; nerr++;
         $display("FAIL %s timeout: no ResultValidM after %0d cycles", name, cyc);
      end
   endtask

   task automatic start(input vec_t v);
      @(negedge clk);
      drive(v);
      StartM = 1'b1;
      sb.push_back(v.exp);
      @(negedge clk);
      StartM = 1'b0;
   endtask

   task automatic pop_check(input string name);
      logic [XLEN-1:0] e;
      e = (sb.size() > 0) ? sb.pop_front() : 'x;
      check(name, IntDivResultM, e);
   endtask

   task automatic handshake(input string name);
      ResultReadyW = 1'b1;
      @(negedge clk);
      ResultReadyW = 1'b0;
      check({name, "_busy_after_hs"}, 64'(BusyM), 64'd0);
      check({name, "_valid_after_hs"}, 64'(ResultValidM), 64'd0);
   endtask

   initial begin
      int cyc;
      tbl[0]  = mk('0, '0, '0, '0, '0, 0, 0, 0, 1, 0, 0, 0, 64'd7, '1, 1);
      tbl[1]  = mk('0, '0, '0, '0, '0, 0, 1, 0, 1, 0, 0, 0, 64'd7, 64'd7, 1);
      tbl[2]  = mk('0, '0, '0, '0, '0, 0, 1, 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD,
                   64'hFFFF_FFFF_FFFF_FFFD, 1);
      tbl[3]  = mk('0, '0, '0, '0, '0, 0, 0, 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1);
      tbl[4]  = mk('0, '0, '0, '0, '0, 0, 0, 1, 1, 0, 0, 0, 64'd5, '1, 1);
      tbl[5]  = mk('0, '0, '0, '0, '0, 0, 1, 0, 1, 0, 0, 1, 64'h0000_0000_8000_0001,
                   64'hFFFF_FFFF_8000_0001, 1);
      tbl[6]  = mk('0, '0, '0, 67'd40, 67'd32, 3, 0, 0, 0, 0, 1, 0, '0,
                   64'hFFFF_FFFF_FFFF_FFFB, 4);
      tbl[7]  = mk('1, '0, '0, 67'd40, 67'd32, 3, 0, 0, 0, 0, 0, 0, '0, 64'd4, 4);
      tbl[8]  = mk('1, '0, 70'd8, 67'd40, 67'd32, 3, 1, 0, 0, 0, 0, 0, '0, 64'd0, 4);
      tbl[9]  = mk('0, '0, '0, 67'h8000_0000, '0, 0, 0, 0, 0, 0, 0, 1, '0,
                   64'hFFFF_FFFF_8000_0000, 4);
      tbl[10] = mk('0, '0, '0, 67'h8000_0000, '0, 0, 0, 0, 0, 0, 0, 0, '0,
                   64'h0000_0000_8000_0000, 4);
      tbl[11] = mk(70'd100, 70'd23, '0, '0, '0, 0, 1, 0, 0, 1, 0, 0, '0,
                   64'hFFFF_FFFF_FFFF_FF85, 4);
      tbl[12] = mk('0, '0, '0, (67'd1 << 66), '0, 66, 0, 0, 0, 1, 1, 0, '0, 64'd1, 4);
      tbl[13] = mk((70'd1 << 69) + 70'd5, (70'd1 << 69), 70'd9, '0, '0, 0, 1, 0, 0, 0, 0, 0,
                   '0, 64'd5, 4);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset_busy", 64'(BusyM), 64'd0);
      check("reset_valid", 64'(ResultValidM), 64'd0);
      check("reset_result", IntDivResultM, 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         start(tbl[i]);
         wait_valid($sformatf("vec%0d", i), cyc);
         check($sformatf("vec%0d_latency", i), 64'(cyc + 1), 64'(tbl[i].lat));
         pop_check($sformatf("vec%0d_result", i));
         handshake($sformatf("vec%0d", i));
      end

      // Result held stable while writeback stalls
      start(tbl[6]);
      wait_valid("stall", cyc);
      pop_check("stall_result");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("stall_valid%0d", k), 64'(ResultValidM), 64'd1);
         check($sformatf("stall_value%0d", k), IntDivResultM, 64'hFFFF_FFFF_FFFF_FFFB);
      end
      handshake("stall");

      // StartM in SHIFT is dropped, not queued
      start(tbl[6]);
      @(negedge clk);
      drive(tbl[0]);
      StartM = 1'b1;
      @(negedge clk);
      StartM = 1'b0;
      @(negedge clk);
      check("ignore_valid", 64'(ResultValidM), 64'd1);
      pop_check("ignore_result");
      handshake("ignore");
      @(negedge clk);
      check("ignore_not_queued", 64'(BusyM), 64'd0);

      // Flush in SUM aborts without a result
      @(negedge clk);
      drive(tbl[7]);
      StartM = 1'b1;
      @(negedge clk);
      StartM = 1'b0;
      FlushM = 1'b1;
      @(negedge clk);
      FlushM = 1'b0;
      check("flush_busy", 64'(BusyM), 64'd0);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("flush_novalid%0d", k), 64'(ResultValidM), 64'd0);
         @(negedge clk);
      end
      check("flush_result_kept", IntDivResultM, 64'hFFFF_FFFF_FFFF_FFFB);

      // Reset asserted while in SIGN clears outputs immediately
      start(tbl[7]);
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_busy", 64'(BusyM), 64'd1);
      reset = 1'b1;
      #1;
      check("midreset_busy", 64'(BusyM), 64'd0);
      check("midreset_valid", 64'(ResultValidM), 64'd0);
      check("midreset_result", IntDivResultM, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      void'(sb.pop_back());

      // Recovery after reset
      start(tbl[7]);
      wait_valid("recover", cyc);
      check("recover_latency", 64'(cyc + 1), 64'd4);
      pop_check("recover_result");
      handshake("recover");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end
endmodule
